// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the nibble index; a single-nibble adder still needs one bit.
  function automatic int nib_idx_w(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4.sv
// 4-bit carry-lookahead adder slice, purely combinational.
module nibble_serial_adder_cla4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin,
  output logic       cout,
  output logic [3:0] s
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate terms with every carry expanded from cin.
  always_comb begin
    g    = A & B;
    p    = A ^ B;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract built around one 4-bit CLA slice.
// One nibble per clock; the registered slice carry chains into the next nibble.
// WIDTH must be a multiple of 4 and at least 4.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last result
// RUN   | one nibble per edge, idx counts 0..NIB-1
// DONE  | single cycle with done=1, result valid
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = nib_idx_w(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   a_q, b_q, sum_q, sum_d;
  logic               carry_q, cout_q, ovf_q;
  logic [NIBBLE_W-1:0] nib_a, nib_b, slice_s;
  logic               slice_cout;
  logic               last_nib;

  assign last_nib = (idx_q == LAST_IDX);

  // Select the operand nibbles addressed by idx.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
        nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  nibble_serial_adder_cla4 u_slice (
    .A   (nib_a),
    .B   (nib_b),
    .cin (carry_q),
    .cout(slice_cout),
    .s   (slice_s)
  );

  // Merge the slice sum into the addressed nibble of the result.
  always_comb begin
    sum_d = sum_q;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDX_W'(i)) sum_d[i*NIBBLE_W +: NIBBLE_W] = slice_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start is only looked at in IDLE, so it never queues.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_nib) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Operand capture and per-nibble datapath; subtract stores ~b with carry-in 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub | cin;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= slice_cout;
          if (last_nib) begin
            cout_q <= slice_cout;
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[NIBBLE_W-1] != a_q[WIDTH-1]);
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst, start, sub, cin;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, cout, ovf;
  logic [WIDTH-1:0] sum;

  int vectors     = 0;
  int miscompares = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic vec_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mc, input logic ms);
    vec_t r;
    int   ua, ub, sa, sb, ures, sres;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (ms) begin
      ures = ua - ub;
      sres = sa - sb;
      r.exp_cout = (ua >= ub);
    end else begin
      ures = ua + ub + int'(mc);
      sres = sa + sb + int'(mc);
      r.exp_cout = (ures > 65535);
    end
    r.a = ma; r.b = mb; r.cin = mc; r.sub = ms;
    r.exp_sum = ures[15:0];
    r.exp_ovf = (sres > 32767) || (sres < -32768);
    return r;
  endfunction

  task automatic do_op(input vec_t v, input string tag);
    int lat, bcnt;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1'b1;
    step();
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      step();
      lat++;
    end
    chk({tag, " latency_edges"}, lat + 1, NIB + 1);
    chk({tag, " busy_cycles"}, bcnt, NIB);
    chk({tag, " busy_in_done"}, busy, 0);
    chk({tag, " sum"}, sum, v.exp_sum);
    chk({tag, " cout"}, cout, v.exp_cout);
    chk({tag, " ovf"}, ovf, v.exp_ovf);
    step();
    chk({tag, " done_one_cycle"}, done, 0);
    chk({tag, " sum_held"}, sum, v.exp_sum);
  endtask

  vec_t tbl[$];

  initial begin
    int dcount;
    vec_t v;

    tbl.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
    tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    tbl.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
    tbl.push_back('{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    tbl.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0});
    tbl.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
    tbl.push_back('{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0});
    tbl.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
    tbl.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0});

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
    chk("reset ovf", ovf, 0);

    foreach (tbl[i]) do_op(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      v = model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      do_op(v, $sformatf("rnd%0d", i));
    end

    // start held high through RUN/DONE must not queue a second request
    a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    step();
    a = 16'hAAAA;
    dcount = 0;
    for (int k = 0; k <= NIB; k++) begin
      if (done) begin
        dcount++;
        chk("held_start sum", sum, 16'h0002);
      end
      if (k < NIB) step();
    end
    step();
    chk("held_start idle busy", busy, 0);
    chk("held_start idle done", done, 0);
    step();
    chk("held_start reaccept busy", busy, 1);
    start = 1'b0;
    chk("held_start done_count", dcount, 1);
    for (int k = 0; k < 40 && !done; k++) step();
    chk("held_start second done", done, 1);
    chk("held_start second sum", sum, 16'hAAAB);
    step();

    // reset on the second RUN edge aborts the operation
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort sum", sum, 0);
    chk("abort cout", cout, 0);
    dcount = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) dcount++;
      step();
    end
    chk("abort no_done", dcount, 0);
    do_op('{16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0}, "after_abort");

    // rst and start at the same edge: rst wins, nothing captured
    a = 16'h1111; b = 16'h2222; start = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    chk("rst_start busy", busy, 0);
    chk("rst_start sum", sum, 0);
    dcount = 0;
    for (int k = 0; k < 8; k++) begin
      if (done || busy) dcount++;
      step();
    end
    chk("rst_start no_capture", dcount, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder/subtractor that sits directly upstream of the team's 4-bit carry-lookahead adder slice. It latches a pair of wide operands, feeds one 4-bit nibble per clock into a single slice instance, and registers the slice's sum and carry. The registered carry chains into the next nibble. The block trades latency for area: one 4-bit slice serves any operand width that is a multiple of 4.

## Interface
Parameters:
- WIDTH, 16: operand/result width; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4: nibble count (derived, not overridden).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0: a+b+cin; 1: a-b (b inverted, carry-in forced 1, cin ignored).
- a  in  WIDTH  operand A, captured with start.
- b  in  WIDTH  operand B, captured with start.
- cin  in  1  carry-in for add, captured with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result becomes valid.
- sum  out  WIDTH  result, held until the next accepted start.
- cout  out  1  carry out of the top nibble (for sub: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge captures a, b (or ~b if sub), and carry register = (sub ? 1 : cin).
  - Clears sum, cout, ovf; sets nibble index idx=0; goes to RUN.
  - start=0 stays in IDLE.
- RUN:
  - Slice inputs: A=a_reg[4*idx+3:4*idx], B=b_reg nibble idx, cin=carry register.
  - Each edge writes the slice sum into sum[4*idx+3:4*idx], loads the slice cout into the carry register, and increments idx.
  - On the edge where idx==NIB-1: cout = slice cout; ovf = (a_reg[WIDTH-1]==b_reg[WIDTH-1]) && (slice s[3]!=a_reg[WIDTH-1]); go to DONE.
- DONE: lasts exactly one cycle with done=1, then returns to IDLE.
- start while in RUN or DONE is ignored; it is not queued.
- Outputs sum/cout/ovf are stable from DONE until the next start is accepted.
- No wrap-around: idx never exceeds NIB-1. Arithmetic is modulo 2^WIDTH, and the carry out is reported only via cout.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state IDLE, idx=0, carry register 0.
- Reset asserted in any state (including mid-RUN) at an edge aborts the operation. Next cycle all outputs are at reset values, and no done is produced for the aborted request.
- rst and start together at the same edge: rst wins.
- Start accepted at edge E0:
  - busy=1 after E0 through edge E_NIB.
  - done=1 for the cycle after E_NIB (latency NIB+1 edges from acceptance).
  - Earliest next acceptance is at edge E_(NIB+2), with WIDTH=16: start at E0, done visible after E4, next start at E6.
- Slice path is combinational inside one cycle. The worst-case 4-bit slice delay plus input muxing must fit in one clock period.

## Structure
- Shared package nsa_pkg:
  - state enum (IDLE, RUN, DONE)
  - NIBBLE_W=4 constant
  - function computing the nibble-index width, $clog2(NIB) with a minimum of 1.
- One sub-module: the existing 4-bit carry-lookahead slice (ports A, B, cin, cout, s), instantiated once.
- Nibble-select muxing and all registers stay in this block.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0, sub=0 -> sum=0x5555, cout=0, ovf=0; done exactly 5 edges after acceptance, busy high for 4 cycles.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry crosses all four nibbles through the carry register).
- a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Then sub=1, a=0x0005, b=0x0007, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored).
- a=0x0001, b=0x0001 accepted; start with a=0xAAAA held high during RUN -> result 0x0002, only one done pulse, next operation starts only after return to IDLE.
- Assert rst on the second RUN edge of a=0xFFFF+0x0001 -> busy=0, sum=0x0000, cout=0, no done pulse; then a fresh 0x0010+0x0020 completes to 0x0030.
- Reset with start held high at the same edge -> stays IDLE, no capture.
